// File: rtl/case_1_mul_share_arb.sv
// case_1_mul_share_arb
// Lets several requesters share a single signed DIN0_W x DIN1_W multiplier.
// A round-robin arbiter feeds a two-register pipeline (S1 operand register,
// then the output register). The product is the low DOUT_W bits of the
// full signed product, so large results wrap in two's complement.
// Every response carries the index of the requester that issued it.
module case_1_mul_share_arb #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DIN0_W = 9,
  parameter int DIN1_W = 8,
  parameter int DOUT_W = 9
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DIN0_W-1:0]    req_a,
  input  logic [N_REQ*DIN1_W-1:0]    req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [DOUT_W-1:0]          resp_data,
  output logic [ID_W-1:0]            resp_id
);

  localparam int PROD_W = DIN0_W + DIN1_W;

  logic                r_s1Valid;
  logic [DIN0_W-1:0]   r_s1A;
  logic [DIN1_W-1:0]   r_s1B;
  logic [ID_W-1:0]     r_s1Id;
  logic [ID_W-1:0]     r_rrPtr;
  logic                r_respValid;
  logic [DOUT_W-1:0]   r_respData;
  logic [ID_W-1:0]     r_respId;

  logic                w_outAdv;
  logic                w_s1Adv;
  logic                w_found;
  logic [ID_W-1:0]     w_gIdx;
  logic [DIN0_W-1:0]   w_selA;
  logic [DIN1_W-1:0]   w_selB;
  logic                w_handshake;
  logic [ID_W-1:0]     w_nextPtr;
  logic [PROD_W-1:0]   w_aExt;
  logic [PROD_W-1:0]   w_bExt;
  logic [PROD_W-1:0]   w_prod;

  // The output register moves when it is empty or being consumed; S1
  // moves when it is empty or can hand its contents to the output stage.
  assign w_outAdv = !r_respValid || resp_ready;
  assign w_s1Adv  = !r_s1Valid || w_outAdv;

  // Both operands are sign-extended to the full product width so the low
  // DOUT_W bits of the multiply are the correctly wrapped signed result.
  assign w_aExt = {{DIN1_W{r_s1A[DIN0_W-1]}}, r_s1A};
  assign w_bExt = {{DIN0_W{r_s1B[DIN1_W-1]}}, r_s1B};
  assign w_prod = w_aExt * w_bExt;

  // Round-robin search starting at the pointer; the first valid requester
  // wins and its operands are selected for capture into S1.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_gIdx  = '0;
    w_selA  = '0;
    w_selB  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_rrPtr) + k) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_gIdx  = ID_W'(idx);
        w_selA  = req_a[idx*DIN0_W +: DIN0_W];
        w_selB  = req_b[idx*DIN1_W +: DIN1_W];
      end
    end
  end

  // Grant is offered only when S1 can accept and never during reset.
  always_comb begin
    req_ready = '0;
    if (!ap_rst && w_s1Adv && w_found) begin
      req_ready[w_gIdx] = 1'b1;
    end
  end

  assign w_handshake = !ap_rst && w_s1Adv && w_found;
  assign w_nextPtr   = (w_gIdx == ID_W'(N_REQ - 1)) ? '0 : w_gIdx + ID_W'(1);

  // Pipeline, output register and round-robin pointer update; reset
  // discards anything in flight so no stale response can appear.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_s1Valid   <= 1'b0;
      r_s1A       <= '0;
      r_s1B       <= '0;
      r_s1Id      <= '0;
      r_rrPtr     <= '0;
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_respId    <= '0;
    end else begin
      if (w_outAdv) begin
        r_respValid <= r_s1Valid;
        if (r_s1Valid) begin
          r_respData <= w_prod[DOUT_W-1:0];
          r_respId   <= r_s1Id;
        end
      end
      if (w_s1Adv) begin
        if (w_handshake) begin
          r_s1Valid <= 1'b1;
          r_s1A     <= w_selA;
          r_s1B     <= w_selB;
          r_s1Id    <= w_gIdx;
          r_rrPtr   <= w_nextPtr;
        end else begin
          r_s1Valid <= 1'b0;
        end
      end
    end
  end

  assign resp_valid = r_respValid;
  assign resp_data  = r_respData;
  assign resp_id    = r_respId;

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Testbench for case_1_mul_share_arb: a table of per-cycle vectors with
// hand-computed grants and responses, followed by hand-written reset
// sequences (initial reset and reset with both pipeline stages full).
module tb_case_1_mul_share_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [35:0] reqA;
  logic [31:0] reqB;
  logic        respValid;
  logic        respReady;
  logic [8:0]  respData;
  logic [1:0]  respId;

  int testsRun;
  int testsFailed;

  typedef struct {
    logic [3:0]  valid;
    logic [35:0] a;
    logic [31:0] b;
    logic        rr;
    logic [3:0]  expReady;
    logic        expValid;
    logic [8:0]  expData;
    logic [1:0]  expId;
  } vec_t;

  vec_t vecs[$];

  case_1_mul_share_arb #(
    .N_REQ(4), .ID_W(2), .DIN0_W(9), .DIN1_W(8), .DOUT_W(9)
  ) dut (
    .ap_clk(clk),
    .ap_rst(rst),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_a(reqA),
    .req_b(reqB),
    .resp_valid(respValid),
    .resp_ready(respReady),
    .resp_data(respData),
    .resp_id(respId)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs away from the rising edge.
  task automatic applyStimulus(input logic r, input logic [3:0] v,
                               input logic [35:0] a, input logic [31:0] b,
                               input logic rr);
    @(negedge clk);
    rst       = r;
    reqValid  = v;
    reqA      = a;
    reqB      = b;
    respReady = rr;
    #1;
  endtask

  // Compare the grant vector and the registered response against expectations.
  task automatic checkOutput(input string name, input logic [3:0] eReady,
                             input logic eValid, input logic [8:0] eData,
                             input logic [1:0] eId);
    testsRun++;
    if (reqReady !== eReady) begin
      testsFailed++;
      $display("[TB] FAIL %s req_ready: got %b, expected %b", name, reqReady, eReady);
    end
    testsRun++;
    if (respValid !== eValid) begin
      testsFailed++;
      $display("[TB] FAIL %s resp_valid: got %b, expected %b", name, respValid, eValid);
    end
    testsRun++;
    if (respData !== eData) begin
      testsFailed++;
      $display("[TB] FAIL %s resp_data: got %h, expected %h", name, respData, eData);
    end
    testsRun++;
    if (respId !== eId) begin
      testsFailed++;
      $display("[TB] FAIL %s resp_id: got %0d, expected %0d", name, respId, eId);
    end
  endtask

  task automatic addVec(input logic [3:0] v, input logic [35:0] a, input logic [31:0] b,
                        input logic rr, input logic [3:0] eReady, input logic eValid,
                        input logic [8:0] eData, input logic [1:0] eId);
    vec_t t;
    t.valid = v; t.a = a; t.b = b; t.rr = rr;
    t.expReady = eReady; t.expValid = eValid; t.expData = eData; t.expId = eId;
    vecs.push_back(t);
  endtask

  // Operand sets: requester i occupies slice i (9-bit A, 8-bit B).
  localparam logic [35:0] A1  = {27'd0, 9'd100};
  localparam logic [31:0] B1  = {24'd0, 8'd3};
  localparam logic [35:0] A2  = {9'd0, 9'h100, 18'd0};
  localparam logic [31:0] B2  = {8'd0, 8'h80, 16'd0};
  localparam logic [35:0] A3  = {9'd0, 9'h1FB, 18'd0};
  localparam logic [31:0] B3  = {8'd0, 8'd7, 16'd0};
  localparam logic [35:0] OPA = {9'h1D8, 9'd30, 9'd20, 9'd10};
  localparam logic [31:0] OPB = {8'd4, 8'd3, 8'd2, 8'd1};

  // Main sequence: table setup, table replay, then reset corner cases.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1; reqValid = '0; reqA = '0; reqB = '0; respReady = 1'b0;

    // Req0 alone: 100*3 = 300 wraps to -212 (0x12C).
    addVec(4'b0001, A1, B1, 1, 4'b0001, 0, 9'h000, 0);
    addVec(4'b0000, A1, B1, 1, 4'b0000, 0, 9'h000, 0);
    addVec(4'b0000, A1, B1, 1, 4'b0000, 1, 9'h12C, 0);
    // Req2 alone: -256*-128 wraps to 0; then -5*7 = -35 (0x1DD).
    addVec(4'b0100, A2, B2, 1, 4'b0100, 0, 9'h12C, 0);
    addVec(4'b0100, A3, B3, 1, 4'b0100, 0, 9'h12C, 0);
    addVec(4'b0000, A3, B3, 1, 4'b0000, 1, 9'h000, 2);
    addVec(4'b0000, A3, B3, 1, 4'b0000, 1, 9'h1DD, 2);
    // All valid, pointer at 3: grants 3,0,1,2,3; products -160,10,40,90.
    addVec(4'b1111, OPA, OPB, 1, 4'b1000, 0, 9'h1DD, 2);
    addVec(4'b1111, OPA, OPB, 1, 4'b0001, 0, 9'h1DD, 2);
    addVec(4'b1111, OPA, OPB, 1, 4'b0010, 1, 9'h160, 3);
    addVec(4'b1111, OPA, OPB, 1, 4'b0100, 1, 9'h00A, 0);
    addVec(4'b1111, OPA, OPB, 1, 4'b1000, 1, 9'h028, 1);
    // Stall five cycles with both stages full: no grant, result held.
    for (int k = 0; k < 5; k++) addVec(4'b1111, OPA, OPB, 0, 4'b0000, 1, 9'h05A, 2);
    // Release: accept-and-issue on one edge, ids stay in order 2,3,0,1.
    addVec(4'b1111, OPA, OPB, 1, 4'b0001, 1, 9'h05A, 2);
    addVec(4'b1111, OPA, OPB, 1, 4'b0010, 1, 9'h160, 3);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h00A, 0);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h028, 1);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 0, 9'h028, 1);
    // Req1 and req3 with pointer at 2: req3 first, then req1.
    addVec(4'b1010, OPA, OPB, 1, 4'b1000, 0, 9'h028, 1);
    addVec(4'b0010, OPA, OPB, 1, 4'b0010, 0, 9'h028, 1);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h160, 3);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h028, 1);
    // Pointer must now be 2: all valid grants req2.
    addVec(4'b1111, OPA, OPB, 1, 4'b0100, 0, 9'h028, 1);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 0, 9'h028, 1);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h05A, 2);
    // Lone requester granted every cycle (pointer wraps 3 -> 0 -> 1).
    addVec(4'b0001, OPA, OPB, 1, 4'b0001, 0, 9'h05A, 2);
    addVec(4'b0001, OPA, OPB, 1, 4'b0001, 0, 9'h05A, 2);
    addVec(4'b0001, OPA, OPB, 1, 4'b0001, 1, 9'h00A, 0);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h00A, 0);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 1, 9'h00A, 0);
    addVec(4'b0000, OPA, OPB, 1, 4'b0000, 0, 9'h00A, 0);

    // Initial reset: grant suppressed while reset is high, then cleared outputs.
    applyStimulus(1, 4'b1111, OPA, OPB, 1);
    testsRun++;
    if (reqReady !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset0 req_ready: got %b, expected 0000", reqReady);
    end
    applyStimulus(1, 4'b1111, OPA, OPB, 1);
    checkOutput("reset1", 4'b0000, 0, 9'h000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(0, vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rr);
      checkOutput($sformatf("vec%0d", i), vecs[i].expReady, vecs[i].expValid,
                  vecs[i].expData, vecs[i].expId);
    end

    // Fill both stages (pointer 1 -> grants 1, 2), stall, then reset mid-flight.
    applyStimulus(0, 4'b1111, OPA, OPB, 0);
    checkOutput("fill0", 4'b0010, 0, 9'h00A, 0);
    applyStimulus(0, 4'b1111, OPA, OPB, 0);
    checkOutput("fill1", 4'b0100, 0, 9'h00A, 0);
    applyStimulus(0, 4'b1111, OPA, OPB, 0);
    checkOutput("full", 4'b0000, 1, 9'h028, 1);
    applyStimulus(1, 4'b1111, OPA, OPB, 0);
    checkOutput("midReset", 4'b0000, 1, 9'h028, 1);
    applyStimulus(0, 4'b0000, OPA, OPB, 1);
    checkOutput("postReset0", 4'b0000, 0, 9'h000, 0);
    applyStimulus(0, 4'b0000, OPA, OPB, 1);
    checkOutput("postReset1", 4'b0000, 0, 9'h000, 0);
    applyStimulus(0, 4'b0000, OPA, OPB, 1);
    checkOutput("postReset2", 4'b0000, 0, 9'h000, 0);
    applyStimulus(0, 4'b1111, OPA, OPB, 1);
    checkOutput("ptrCleared", 4'b0001, 0, 9'h000, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
